// File: rtl/tof_delay_sweeper.sv
`default_nettype none
// ============================================================================
// Module   : tof_delay_sweeper
// Steps a delay-line tap across a range, fires trigger bursts and reports echo hits per tap.
// Revision : 1.0
// ============================================================================
module tof_delay_sweeper #(
   parameter int PULSE_LEN = 4,
   parameter int SHOTS_W   = 16
) (
   input  logic               io_mainClk,
   input  logic               io_reset,
   input  logic               cfg_start,
   input  logic               cfg_abort,
   input  logic [7:0]         cfg_delayFirst,
   input  logic [7:0]         cfg_delayLast,
   input  logic [7:0]         cfg_delayStep,
   input  logic [SHOTS_W-1:0] cfg_shots,
   input  logic [7:0]         cfg_settle,
   input  logic [7:0]         cfg_window,
   input  logic               io_trigsIn,
   output logic               io_trigsOut,
   output logic [7:0]         io_delay,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [7:0]         res_delay,
   output logic [SHOTS_W-1:0] res_hits,
   output logic               busy,
   output logic               done
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SETTLE = 3'd1;
   localparam logic [2:0] S_FIRE   = 3'd2;
   localparam logic [2:0] S_LISTEN = 3'd3;
   localparam logic [2:0] S_REPORT = 3'd4;

   localparam logic [7:0]         C_PULSE_LAST = 8'(PULSE_LEN - 1);
   localparam logic [SHOTS_W-1:0] C_ONE        = SHOTS_W'(1);

   logic [2:0]         r_state;
   logic [2:0]         w_next_state;

   logic               r_sync1;
   logic               r_sync2;
   logic               r_sync3;
   logic               w_echo_edge;

   logic [7:0]         r_last;
   logic [7:0]         r_step;
   logic [SHOTS_W-1:0] r_shots;
   logic [7:0]         r_settle;
   logic [7:0]         r_window;

   logic [7:0]         r_cnt;
   logic [SHOTS_W-1:0] r_shot_cnt;
   logic [SHOTS_W-1:0] r_hits;
   logic               r_hit_seen;
   logic [7:0]         r_delay;
   logic               r_done;

   logic               w_start;
   logic               w_settle_end;
   logic               w_fire_end;
   logic               w_listen_end;
   logic [SHOTS_W-1:0] w_shot_inc;
   logic               w_more_shots;
   logic               w_xfer;
   logic [8:0]         w_sum;
   logic               w_last_tap;

   // Two-flop synchronizer plus one history flop for rising-edge detection
   always_ff @(posedge io_mainClk) begin
      if (io_reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_sync3 <= 1'b0;
      end else begin
         r_sync1 <= io_trigsIn;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
      end
   end

   assign w_echo_edge  = r_sync2 & ~r_sync3;

   assign w_start      = (r_state == S_IDLE) & cfg_start & ~cfg_abort;
   assign w_settle_end = (r_state == S_SETTLE) && (r_cnt == r_settle - 8'd1);
   assign w_fire_end   = (r_state == S_FIRE)   && (r_cnt == C_PULSE_LAST);
   assign w_listen_end = (r_state == S_LISTEN) && (r_cnt == r_window - 8'd1);
   assign w_shot_inc   = r_shot_cnt + C_ONE;
   assign w_more_shots = (w_shot_inc < r_shots);
   assign w_xfer       = (r_state == S_REPORT) & res_ready;
   assign w_sum        = {1'b0, r_delay} + {1'b0, r_step};
   assign w_last_tap   = w_sum[8] | (w_sum > {1'b0, r_last});

   always_ff @(posedge io_mainClk) begin
      if (io_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:   if (w_start)      w_next_state = S_SETTLE;
         S_SETTLE: if (w_settle_end) w_next_state = S_FIRE;
         S_FIRE:   if (w_fire_end)   w_next_state = S_LISTEN;
         S_LISTEN: if (w_listen_end) w_next_state = w_more_shots ? S_FIRE : S_REPORT;
         S_REPORT: if (w_xfer)       w_next_state = w_last_tap ? S_IDLE : S_SETTLE;
         default:                    w_next_state = S_IDLE;
      endcase
      if (cfg_abort) begin
         w_next_state = S_IDLE;
      end
   end

   // Zero-valued step/shots/settle/window are normalised to 1 at latch time
   always_ff @(posedge io_mainClk) begin
      if (io_reset) begin
         r_last     <= 8'd0;
         r_step     <= 8'd1;
         r_shots    <= C_ONE;
         r_settle   <= 8'd1;
         r_window   <= 8'd1;
         r_cnt      <= 8'd0;
         r_shot_cnt <= '0;
         r_hits     <= '0;
         r_hit_seen <= 1'b0;
         r_delay    <= 8'd0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (cfg_abort) begin
            r_cnt <= 8'd0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (cfg_start) begin
                     r_last     <= cfg_delayLast;
                     r_step     <= (cfg_delayStep == 8'd0) ? 8'd1 : cfg_delayStep;
                     r_shots    <= (cfg_shots == '0) ? C_ONE : cfg_shots;
                     r_settle   <= (cfg_settle == 8'd0) ? 8'd1 : cfg_settle;
                     r_window   <= (cfg_window == 8'd0) ? 8'd1 : cfg_window;
                     r_delay    <= cfg_delayFirst;
                     r_cnt      <= 8'd0;
                     r_shot_cnt <= '0;
                     r_hits     <= '0;
                  end
               end
               S_SETTLE: begin
                  r_cnt <= w_settle_end ? 8'd0 : r_cnt + 8'd1;
               end
               S_FIRE: begin
                  r_cnt      <= w_fire_end ? 8'd0 : r_cnt + 8'd1;
                  r_hit_seen <= 1'b0;
               end
               S_LISTEN: begin
                  r_cnt <= w_listen_end ? 8'd0 : r_cnt + 8'd1;
                  // Only the first echo of each listen window counts
                  if (w_echo_edge && !r_hit_seen) begin
                     r_hit_seen <= 1'b1;
                     if (r_hits != '1) begin
                        r_hits <= r_hits + C_ONE;
                     end
                  end
                  if (w_listen_end) begin
                     r_shot_cnt <= w_shot_inc;
                  end
               end
               S_REPORT: begin
                  if (w_xfer) begin
                     if (w_last_tap) begin
                        r_done <= 1'b1;
                     end else begin
                        r_delay    <= w_sum[7:0];
                        r_shot_cnt <= '0;
                        r_hits     <= '0;
                        r_cnt      <= 8'd0;
                     end
                  end
               end
               default: begin
                  r_cnt <= 8'd0;
               end
            endcase
         end
      end
   end

   // Abort forces trigger and result-valid low in the same cycle it is raised
   always_comb begin
      io_trigsOut = 1'b0;
      res_valid   = 1'b0;
      busy        = (r_state != S_IDLE);
      if (!cfg_abort) begin
         io_trigsOut = (r_state == S_FIRE);
         res_valid   = (r_state == S_REPORT);
      end
   end

   assign io_delay  = r_delay;
   assign res_delay = r_delay;
   assign res_hits  = r_hits;
   assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_tof_delay_sweeper.sv
`default_nettype none
// Testbench for tof_delay_sweeper: echo responder, result scoreboard and directed sweeps.
`timescale 1ns/1ps
module tb_tof_delay_sweeper;

   localparam int PULSE_LEN = 4;
   localparam int SHOTS_W   = 16;

   logic               io_mainClk = 1'b0;
   logic               io_reset   = 1'b1;
   logic               cfg_start  = 1'b0;
   logic               cfg_abort  = 1'b0;
   logic [7:0]         cfg_delayFirst = 8'd0;
   logic [7:0]         cfg_delayLast  = 8'd0;
   logic [7:0]         cfg_delayStep  = 8'd0;
   logic [SHOTS_W-1:0] cfg_shots      = '0;
   logic [7:0]         cfg_settle     = 8'd0;
   logic [7:0]         cfg_window     = 8'd0;
   logic               io_trigsIn = 1'b0;
   logic               io_trigsOut;
   logic [7:0]         io_delay;
   logic               res_valid;
   logic               res_ready = 1'b1;
   logic [7:0]         res_delay;
   logic [SHOTS_W-1:0] res_hits;
   logic               busy;
   logic               done;

   tof_delay_sweeper #(.PULSE_LEN(PULSE_LEN), .SHOTS_W(SHOTS_W)) dut (
      .io_mainClk     (io_mainClk),
      .io_reset       (io_reset),
      .cfg_start      (cfg_start),
      .cfg_abort      (cfg_abort),
      .cfg_delayFirst (cfg_delayFirst),
      .cfg_delayLast  (cfg_delayLast),
      .cfg_delayStep  (cfg_delayStep),
      .cfg_shots      (cfg_shots),
      .cfg_settle     (cfg_settle),
      .cfg_window     (cfg_window),
      .io_trigsIn     (io_trigsIn),
      .io_trigsOut    (io_trigsOut),
      .io_delay       (io_delay),
      .res_valid      (res_valid),
      .res_ready      (res_ready),
      .res_delay      (res_delay),
      .res_hits       (res_hits),
      .busy           (busy),
      .done           (done)
   );

   always #5 io_mainClk = ~io_mainClk;

   typedef struct {
      int delay;
      int hits;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   // Echo responder: pulses io_trigsIn d0 (and optionally d0+2) negedges after a trigger fall
   int   echo_d0    = 0;
   bit   echo_multi = 1'b0;
   int   k_since    = 255;
   logic prev_trig  = 1'b0;
   always @(negedge io_mainClk) begin
      if (prev_trig && !io_trigsOut) k_since = 0;
      else if (k_since < 255) k_since++;
      prev_trig  = io_trigsOut;
      io_trigsIn = (k_since == echo_d0) || (echo_multi && (k_since == echo_d0 + 2));
   end

   // Output monitor: result scoreboard, done counting, trigger width and count
   int   done_cnt   = 0;
   int   trig_rises = 0;
   int   hi_run     = 0;
   bit   skip_width = 1'b0;
   logic mon_trig   = 1'b0;
   always @(negedge io_mainClk) begin
      exp_t e;
      if (io_reset) begin
         hi_run = 0;
      end else begin
         if (done) done_cnt++;
         if (res_valid && res_ready) begin
            if (sb_q.size() == 0) begin
               check("res_unexpected", res_valid, 0);
            end else begin
               e = sb_q.pop_front();
               check("res_delay", res_delay, e.delay);
               check("res_hits", res_hits, e.hits);
            end
         end
         if (io_trigsOut && !mon_trig) trig_rises++;
         if (io_trigsOut) begin
            hi_run++;
         end else begin
            if (hi_run != 0 && !skip_width) check("trig_width", hi_run, PULSE_LEN);
            hi_run = 0;
         end
      end
      mon_trig = io_trigsOut;
   end

   task automatic tick();
      @(posedge io_mainClk);
      #1;
   endtask

   task automatic run_sweep(input int first, input int last, input int step, input int shots,
                            input int settle, input int window, input int d0, input bit multi,
                            input bit bp);
      int   st, sh, w, d, taps, hits, done0, rises0, cyc;
      exp_t e;
      st   = (step == 0) ? 1 : step;
      sh   = (shots == 0) ? 1 : shots;
      w    = (window == 0) ? 1 : window;
      hits = (d0 <= w - 3) ? sh : 0;
      d    = first;
      taps = 0;
      while (1) begin
         e.delay = d;
         e.hits  = hits;
         sb_q.push_back(e);
         taps++;
         if (d + st > last || d + st > 255) break;
         d += st;
      end
      echo_d0    = d0;
      echo_multi = multi;
      done0      = done_cnt;
      rises0     = trig_rises;
      res_ready  = !bp;
      cfg_delayFirst = 8'(first);
      cfg_delayLast  = 8'(last);
      cfg_delayStep  = 8'(step);
      cfg_shots      = SHOTS_W'(shots);
      cfg_settle     = 8'(settle);
      cfg_window     = 8'(window);
      cfg_start      = 1'b1;
      tick();
      cfg_start      = 1'b0;
      // Later cfg changes must not disturb the running sweep
      cfg_delayFirst = 8'h77;
      cfg_delayLast  = 8'h01;
      cfg_delayStep  = 8'h03;
      cfg_shots      = SHOTS_W'(9);
      cfg_window     = 8'd1;
      cfg_settle     = 8'd7;
      if (bp) begin
         cyc = 0;
         while (!res_valid && cyc < 2000) begin
            tick();
            cyc++;
         end
         check("bp_wait_valid", res_valid, 1);
         repeat (20) begin
            check("bp_valid", res_valid, 1);
            check("bp_delay", res_delay, first);
            check("bp_hits", res_hits, hits);
            check("bp_trig", io_trigsOut, 0);
            tick();
         end
         res_ready = 1'b1;
      end
      cyc = 0;
      while (done_cnt == done0 && cyc < 20000) begin
         tick();
         cyc++;
      end
      check("sweep_timeout", (cyc < 20000), 1);
      repeat (3) tick();
      check("done_pulses", done_cnt - done0, 1);
      check("busy_after_done", busy, 0);
      check("results_left", sb_q.size(), 0);
      check("trig_count", trig_rises - rises0, taps * sh);
      sb_q.delete();
   endtask

   task automatic abort_mid_fire(input bit use_reset);
      int done0, cyc;
      done0      = done_cnt;
      skip_width = 1'b1;
      res_ready  = 1'b1;
      cfg_delayFirst = 8'd33;
      cfg_delayLast  = 8'd40;
      cfg_delayStep  = 8'd1;
      cfg_shots      = SHOTS_W'(3);
      cfg_settle     = 8'd2;
      cfg_window     = 8'd5;
      cfg_start      = 1'b1;
      tick();
      cfg_start      = 1'b0;
      cyc = 0;
      while (!io_trigsOut && cyc < 200) begin
         tick();
         cyc++;
      end
      check("abort_wait_fire", io_trigsOut, 1);
      tick();
      if (use_reset) io_reset = 1'b1;
      else cfg_abort = 1'b1;
      tick();
      io_reset  = 1'b0;
      cfg_abort = 1'b0;
      check(use_reset ? "rst_trig" : "abort_trig", io_trigsOut, 0);
      check(use_reset ? "rst_busy" : "abort_busy", busy, 0);
      check(use_reset ? "rst_valid" : "abort_valid", res_valid, 0);
      check(use_reset ? "rst_delay" : "abort_delay", io_delay, use_reset ? 0 : 33);
      repeat (40) tick();
      check(use_reset ? "rst_no_done" : "abort_no_done", done_cnt - done0, 0);
      check(use_reset ? "rst_idle" : "abort_idle", busy, 0);
      skip_width = 1'b0;
   endtask

   initial begin
      repeat (3) tick();
      check("rst_trigsOut", io_trigsOut, 0);
      check("rst_io_delay", io_delay, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_res_delay", res_delay, 0);
      check("rst_res_hits", res_hits, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      io_reset = 1'b0;
      tick();

      run_sweep(10, 12, 1, 3, 2, 5, 2, 1'b0, 1'b0);    // basic three-tap sweep
      run_sweep(20, 20, 1, 2, 3, 5, 0, 1'b0, 1'b1);    // backpressure in REPORT
      run_sweep(30, 31, 1, 4, 1, 3, 0, 1'b0, 1'b0);    // echo lands on last window clock
      run_sweep(40, 41, 1, 3, 1, 5, 0, 1'b1, 1'b0);    // two echoes per window
      run_sweep(50, 50, 1, 3, 1, 5, 3, 1'b0, 1'b0);    // echo just after window
      run_sweep(250, 255, 4, 1, 1, 5, 0, 1'b0, 1'b0);  // no wrap past 255
      run_sweep(5, 6, 0, 0, 0, 0, 0, 1'b0, 1'b0);      // zero config fields
      run_sweep(100, 90, 1, 2, 1, 4, 0, 1'b0, 1'b0);   // first > last: single tap
      abort_mid_fire(1'b0);
      run_sweep(10, 11, 1, 1, 1, 5, 1, 1'b0, 1'b0);
      abort_mid_fire(1'b1);
      run_sweep(60, 62, 2, 2, 2, 6, 1, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/tof_delay_sweeper.md
TOF_DELAY_SWEEPER -- requirements
Module: tof_delay_sweeper

Interface
REQ-001 SHALL have parameter PULSE_LEN, default 4, trigger pulse width in clocks (1..255).
REQ-002 SHALL have parameter SHOTS_W, default 16, width of shot and hit counters.
REQ-003 SHALL have port io_mainClk, in, 1, sole clock; all logic rising-edge.
REQ-004 SHALL have port io_reset, in, 1, synchronous active-high reset.
REQ-005 SHALL have port cfg_start, in, 1, one-cycle sweep request; ignored unless IDLE.
REQ-006 SHALL have port cfg_abort, in, 1, return to IDLE at next edge; dominates cfg_start.
REQ-007 SHALL have ports cfg_delayFirst, cfg_delayLast, cfg_delayStep, in, 8 each, sweep range and increment.
REQ-008 SHALL have port cfg_shots, in, SHOTS_W, shots per delay tap.
REQ-009 SHALL have ports cfg_settle, cfg_window, in, 8 each, settle and listen lengths in clocks.
REQ-010 SHALL have port io_trigsIn, in, 1, asynchronous echo input.
REQ-011 SHALL have port io_trigsOut, out, 1, emitter trigger pulse.
REQ-012 SHALL have port io_delay, out, 8, delay-line tap select.
REQ-013 SHALL have ports res_valid out 1, res_ready in 1, res_delay out 8, res_hits out SHOTS_W, per-tap result stream.
REQ-014 SHALL have ports busy out 1 (state != IDLE) and done out 1 (one-cycle end-of-sweep pulse).

Function
REQ-015 SHALL latch all cfg_* inputs on accepted cfg_start; later cfg_* changes do not affect a running sweep.
REQ-016 SHALL treat latched cfg_delayStep=0, cfg_shots=0, cfg_settle=0, cfg_window=0 as 1.
REQ-017 SHALL synchronize io_trigsIn with two flops and detect rising edges on the synchronized signal.
REQ-018 SHALL implement states IDLE, SETTLE, FIRE, LISTEN, REPORT.
REQ-019 SHALL go IDLE->SETTLE on accepted start, with io_delay=cfg_delayFirst, hit counter and shot counter cleared.
REQ-020 SHALL stay in SETTLE exactly cfg_settle clocks, then enter FIRE.
REQ-021 SHALL assert io_trigsOut for exactly PULSE_LEN clocks while in FIRE, then enter LISTEN; io_trigsOut low in every other state.
REQ-022 SHALL stay in LISTEN exactly cfg_window clocks; first synchronized rising edge in that window increments hits by 1; further edges in same window ignored; edges outside LISTEN ignored.
REQ-023 SHALL after LISTEN increment shot count; if shots < cfg_shots enter FIRE (no re-settle), else enter REPORT.
REQ-024 SHALL in REPORT hold res_valid=1, res_delay=io_delay, res_hits stable until res_ready=1; transfer occurs on edge with both high.
REQ-025 SHALL after transfer: if io_delay + cfg_delayStep (9-bit sum) > cfg_delayLast or >255, pulse done and go IDLE; else load new io_delay, clear counters, enter SETTLE.
REQ-026 SHALL, if cfg_delayFirst > cfg_delayLast, still measure and report exactly one tap (cfg_delayFirst).
REQ-027 SHALL saturate hits at all-ones (cannot exceed cfg_shots in practice).
REQ-028 SHALL on cfg_abort in any state: io_trigsOut low, res_valid low, go IDLE next edge, no done pulse, io_delay held.
REQ-029 SHALL keep io_delay constant from SETTLE entry until the following REPORT transfer.

Reset
REQ-030 SHALL on io_reset: state IDLE, io_trigsOut=0, io_delay=0, res_valid=0, res_delay=0, res_hits=0, busy=0, done=0, sync flops 0.
REQ-031 SHALL honour reset mid-sweep with identical result; reset dominates cfg_abort and cfg_start.

Verification
REQ-032 Basic: first=10,last=12,step=1,shots=3,settle=2,window=5, echo 2 clocks after each trigger fall, res_ready=1 -> three results (10,3),(11,3),(12,3), then done pulse.
REQ-033 Backpressure: res_ready=0 for 20 clocks in REPORT -> res_valid, res_delay, res_hits stable all 20 clocks; io_trigsOut stays 0.
REQ-034 Window edges: echo at window clock 1, multiple echoes in one window, echo one clock after window -> hits count only first in-window echo per shot.
REQ-035 Wrap: first=250,last=255,step=4 -> taps 250,254 reported, no 258/2 wrap, done after 254.
REQ-036 Zero cfg: step=0,shots=0,settle=0,window=0, first=5,last=6 -> taps 5,6, one shot each, 1-clock settle and window.
REQ-037 Abort/reset mid-FIRE: io_trigsOut low next edge, busy=0, no result, no done; new cfg_start afterwards runs normally.
